// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
// States, opcodes and datapath mux select codes.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10,
    LUI      = 4'd11,
    AUIPC    = 4'd12,
    TRAP     = 4'd13
  } statetype_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    logic [2:0] s;
    s = IMM_I;
    unique case (1'b1)
      (op == OP_STORE):                     s = IMM_S;
      (op == OP_BRANCH):                    s = IMM_B;
      (op == OP_JAL):                       s = IMM_J;
      (op == OP_LUI) || (op == OP_AUIPC):   s = IMM_U;
      default:                              s = IMM_I;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_aludec.sv
// ALU operation decoder: ALUOp plus funct fields to ALUControl.
// Subtract only for R-type with funct7b5 set.
module riscv_mc_aludec
  import riscv_mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    unique case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct3)
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b100:  alucontrol = ALU_XOR;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM for the shared-datapath multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback, traps on bad opcodes.
module riscv_multicycle_ctrl
  import riscv_mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               MemWrite,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [2:0]         ImmSrc,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
);

  statetype_t state;
  aluop_t     aluop;
  logic       req, mw, irw, pcw, rw;
  logic       br_take;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= FETCH;
      illegal <= 1'b0;
    end else begin
      unique case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          unique case (1'b1)
            (op == OP_LOAD),
            (op == OP_STORE):  state <= MEMADR;
            (op == OP_RTYPE):  state <= EXECR;
            (op == OP_ITYPE):  state <= EXECI;
            (op == OP_BRANCH): state <= BRANCH;
            (op == OP_JAL):    state <= JAL;
            (op == OP_LUI):    state <= LUI;
            (op == OP_AUIPC):  state <= AUIPC;
            default: begin
              state   <= TRAP;
              illegal <= 1'b1;
            end
          endcase
        end
        MEMADR:   state <= op[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  if (mem_ready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (mem_ready) state <= FETCH;
        EXECR:    state <= ALUWB;
        ALUWB:    state <= FETCH;
        EXECI:    state <= ALUWB;
        JAL:      state <= ALUWB;
        BRANCH:   state <= FETCH;
        LUI:      state <= ALUWB;
        AUIPC:    state <= ALUWB;
        TRAP:     state <= TRAP;
        default:  state <= FETCH;
      endcase
    end
  end

  // Only beq/bne are supported; other branch funct3 never redirect.
  assign br_take = (Zero ^ funct3[0]) & ~funct3[2] & ~funct3[1];

  always_comb begin
    req       = 1'b0;
    mw        = 1'b0;
    irw       = 1'b0;
    pcw       = 1'b0;
    rw        = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    aluop     = ALUOP_ADD;
    unique case (state)
      FETCH: begin
        req       = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        irw       = mem_ready;
        pcw       = mem_ready;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        req    = 1'b1;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        rw        = 1'b1;
      end
      MEMWRITE: begin
        req    = 1'b1;
        mw     = 1'b1;
        AdrSrc = 1'b1;
      end
      EXECR: begin
        ALUSrcA = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: rw = 1'b1;
      EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pcw     = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = SRCA_RS1;
        aluop   = ALUOP_SUB;
        pcw     = br_take;
      end
      LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
      end
      AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      default: ;
    endcase
  end

  assign mem_req   = req & reset;
  assign MemWrite  = mw & reset;
  assign IRWrite   = irw & reset;
  assign PCWrite   = pcw & reset;
  assign RegWrite  = rw & reset;
  assign ImmSrc    = imm_sel(op);
  assign dbg_state = STATE_W'(state);

  riscv_mc_aludec u_aludec (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (ALUControl)
  );

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
Main control FSM that sequences the shared RV32I datapath (single ALU, unified memory port) one instruction over 3–5 cycles. It waits on memory through a req/ready handshake. It drives every mux select and write enable, including the IR, PC, register-file and memory strobes, and traps on unsupported opcodes. It sits beside the datapath in the multicycle processor top, replacing the single-cycle controller.

Parameters:
- STATE_W, 4, width of the state register and of dbg_state.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- op  in  7  Instr[6:0], taken from the IR
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  store strobe, qualifies mem_req
- AdrSrc  out  1  memory address select: 0=PC, 1=Result
- IRWrite  out  1  IR and OldPC load enable
- PCWrite  out  1  PC load enable
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1, 11=zero
- ALUSrcB  out  2  00=rs2, 01=ImmExt, 10=const 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 100 xor
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- illegal  out  1  sticky trap flag
- dbg_state  out  STATE_W  current state

Behaviour:
- Reset: on a clk edge with reset=0, state<=FETCH and illegal<=0. While reset=0, all enables are forced to 0: mem_req, MemWrite, IRWrite, PCWrite, RegWrite.
- Outputs are Moore, decoded from state. Exceptions: PCWrite/IRWrite depend on mem_ready, branch PCWrite depends on Zero, and ImmSrc/ALUControl depend on op/funct3/funct7b5.
- Unlisted outputs in any state are 0.
- ALUOp is internal: add, sub, or funct-decoded.
  - Funct decode: funct3 000 → add; sub only if op[5]&funct7b5; 010→slt, 100→xor, 110→or, 111→and; others → add.
- ImmSrc comes from op: load/I-ALU=I, store=S, branch=B, jal=J, lui/auipc=U.
- States and transitions:
  - FETCH(0): mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. When mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE. Otherwise stay, with IRWrite=PCWrite=0.
  - DECODE(1): ALUSrcA=01, ALUSrcB=01, add (branch/jal target into ALUOut). Next state by op:
    - 0000011 → MEMADR
    - 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 0110111 → LUI
    - 0010111 → AUIPC
    - otherwise → TRAP
  - MEMADR(2): ALUSrcA=10, ALUSrcB=01, add. Next is MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD(3): mem_req=1, AdrSrc=1, ResultSrc=00. Stay until mem_ready, then go to MEMWB.
  - MEMWB(4): ResultSrc=01, RegWrite=1, then FETCH.
  - MEMWRITE(5): mem_req=1, MemWrite=1, AdrSrc=1, ResultSrc=00. Hold all until mem_ready, then FETCH.
  - EXECR(6): ALUSrcA=10, ALUSrcB=00, funct decode, then ALUWB.
  - ALUWB(7): ResultSrc=00, RegWrite=1, then FETCH.
  - EXECI(8): ALUSrcA=10, ALUSrcB=01, funct decode, then ALUWB.
  - JAL(9): ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB.
  - BRANCH(10): ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = Zero ^ funct3[0] (beq/bne only), then FETCH.
  - LUI(11): ALUSrcA=11, ALUSrcB=01, add, then ALUWB.
  - AUIPC(12): ALUSrcA=01, ALUSrcB=01, add, then ALUWB.
  - TRAP(13): illegal=1, all enables 0. Only reset leaves this state.
  - Codes 14–15 go to FETCH.
- Latency with mem_ready always 1:
  - lw = 5 cycles
  - sw = 4 cycles
  - R/I/lui/auipc/jal = 4 cycles
  - branch = 3 cycles
- Any mem_ready wait adds one cycle per stalled cycle.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- Reset asserted mid-wait: state returns to FETCH on the next edge, and the pending request is dropped. No handshake is owed to memory.

Decomposition:
- Package riscv_mc_pkg holds:
  - the state enum statetype_t with the encodings above;
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC);
  - encodings for ALUSrcA, ALUSrcB, ResultSrc and ImmSrc.
- One sub-module, riscv_mc_aludec: combinational ALUOp/funct3/funct7b5/op[5] → ALUControl.

Test Plan:
- reset=0 for 2 cycles, then mem_ready=1, op=0000011 → dbg_state sequence 0,1,2,3,4,0. IRWrite=1 in cycle 0, RegWrite=1 only in state 4, ResultSrc=01.
- sw with mem_ready held low for 3 cycles in MEMWRITE → MemWrite=mem_req=1 for 4 cycles, and the state sequence is 0,1,2,5,5,5,5,0.
- beq (funct3=000), first with Zero=1, then with Zero=0 → PCWrite=1, then PCWrite=0, in state 10. bne (funct3=001) with Zero=0 → PCWrite=1.
- R-type sub (op=0110011, funct3=000, funct7b5=1) → ALUControl=001 in EXECR. The same with op=0010011 (addi) → ALUControl=000.
- op=1111111 in DECODE → state 13 and illegal=1, held with mem_ready toggling for 10 cycles. reset=0 for one edge → state 0, illegal=0.
- reset=0 asserted while in MEMREAD stalled (mem_ready=0) → next edge state=0 and all enables 0 during reset. After release, FETCH issues mem_req=1.
